seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Watches a qualified 1-bit input stream and pulses z when the last N received bits equal a runtime-programmable pattern.
- Pattern length and overlap mode are configurable at runtime. Counts matches and records the stream position of the most recent match.
- Generalises the team's fixed 5-bit "10010" detector FSM. Used in serial-link framing and protocol-sniffer paths.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (legal 2..32).
- CNT_W, 16, width of the match counter and the bit-position counter.
- LEN_W, $clog2(MAX_LEN)+1, localparam, width of cfg_len (not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- x_valid  in  1  x is sampled only when high.
- x  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len, cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit expected, bit [0] the last.
- cfg_len  in  LEN_W  active pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = restart after each match.
- clr_cnt  in  1  synchronous clear of match_cnt and cnt_sat.
- z  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating match count.
- cnt_sat  out  1  sticky; high once match_cnt has reached all-ones.
- last_pos  out  CNT_W  bit index (0-based, wrapping) of the bit that completed the latest match.

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- Reset values:
  - z=0, match_cnt=0, cnt_sat=0, last_pos=0.
  - Internal state: hist=0, fill=0, bit_idx=0.
  - Active config: pattern = 10010 in bits [4:0] (others 0), len=5, overlap=1. The block therefore powers up equivalent to the legacy detector.
- Config latch:
  - On cfg_load, the active config takes the inputs on the next edge.
  - cfg_len of 0 or 1 is clamped to 2; cfg_len > MAX_LEN is clamped to MAX_LEN.
  - Load also clears hist and fill. bit_idx and the counters are kept.
- Data path, on each x_valid cycle without cfg_load:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - bit_idx <= bit_idx+1, wrapping modulo 2^CNT_W.
- Match condition, evaluated on the same cycle:
  - (fill+1 >= len) AND ({hist[MAX_LEN-2:0],x} masked to the low len bits == pattern masked to the low len bits).
  - The fill gate prevents false matches on reset or zero-filled history.
- On match:
  - z=1 on the following cycle, for exactly 1 cycle.
  - last_pos <= current bit_idx.
  - match_cnt increments unless already all-ones; cnt_sat sets when match_cnt becomes all-ones.
  - If overlap=0, fill <= 0, so the next match needs len fresh bits. If overlap=1, fill continues.
- x_valid low: no state change; z=0 the following cycle.
- Latency: x to z is 1 cycle, fully pipelined; one match per valid bit is possible (e.g. pattern 11 with overlap=1).
- Simultaneous events:
  - cfg_load with x_valid: load wins, the bit is discarded, and bit_idx does not advance.
  - clr_cnt with a match: match_cnt=1, cnt_sat=0.
  - clr_cnt with cnt_sat: both clear.
- Reset mid-stream: all state returns to reset values immediately (asynchronous); a z pulse in flight is lost.
- Implementation: no casex; single registered-output FSM-free shift/compare structure plus counters.

Decomposition:
- Shared package seqdet_pkg:
  - Default pattern constant DEF_PATTERN = 5'b10010, DEF_LEN = 5.
  - Function clamp_len.
  - Function len_mask(len) returning a MAX_LEN-bit mask.
- One natural sub-module, sat_counter (CNT_W, sync clear, increment, saturate flag), instantiated for match_cnt.
- bit_idx is a plain wrapping counter, inline.

Test Plan:
- Reset defaults:
  - Stimulus: after reset, stream 1,0,0,1,0,0,1,0 (all valid).
  - Required: z pulses after bits 5 and 8 (overlap); match_cnt=2; last_pos=7.
- Non-overlap:
  - Stimulus: cfg_load pattern=0b11, len=2, overlap=0; stream 1,1,1,1,1.
  - Required: matches at bit_idx 1 and 3 only; match_cnt=2.
- Overlap:
  - Stimulus: same stream as non-overlap with overlap=1.
  - Required: z high on 4 consecutive cycles; match_cnt=4.
- Gaps and fill gate:
  - Stimulus: pattern 10010 with x_valid toggling every other cycle.
  - Required: the match still fires exactly once, 1 cycle after the fifth valid bit.
  - Stimulus: load pattern 0000 (len 4), then feed 3 zeros.
  - Required: no match (fill gate); the 4th zero matches.
- Boundaries:
  - cfg_len=0 clamps to 2; cfg_len=15 with MAX_LEN=8 clamps to 8; a full 8-bit pattern 0xA5 is detected.
  - cfg_load coincident with x_valid: the bit is dropped and bit_idx is unchanged.
- Saturation and clear:
  - Stimulus: CNT_W=4, 16 matches.
  - Required: match_cnt=15 and cnt_sat=1 after the 15th match, both held on the 16th.
  - Stimulus: clr_cnt coincident with a match.
  - Required: match_cnt=1, cnt_sat=0.
  - Stimulus: async reset asserted mid-pattern.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seqdet_pkg;

  // Legacy detector pattern, loaded at reset.
  localparam logic [4:0] DEF_PATTERN = 5'b10010;
  localparam int         DEF_LEN     = 5;

  // Force a requested pattern length into the legal range 2..max_len.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 2)
      return 2;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

  // Ones in the low 'len' bit positions; callers narrow it to MAX_LEN bits.
  function automatic logic [31:0] len_mask(input int len);
    if (len >= 32)
      return '1;
    else
      return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Clear has priority but still counts a coincident increment; count stops at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CNT_W'(1) : '0;
      r_sat <= i_inc && (CNT_W == 1);
    end else if (i_inc && (r_cnt != ALL_ONES)) begin
      r_cnt <= w_cnt_inc;
      r_sat <= (w_cnt_inc == ALL_ONES);
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern, length and overlap mode.
// Registered match pulse, saturating match counter and last-match position.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic [CNT_W-1:0]   last_pos
);

  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
  localparam logic [LEN_W-1:0]   FILL_MAX    = LEN_W'(MAX_LEN);

  // Active configuration.
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  // The oldest of MAX_LEN bits is never compared again, so only MAX_LEN-1 are kept.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_last_pos;
  logic               r_z;

  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_cfg_len;
  logic [LEN_W-1:0]   w_fill_inc;
  logic               w_fill_ok;
  logic               w_advance;
  logic               w_match;

  assign w_cfg_len  = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
  assign w_window   = {r_hist, x};
  assign w_mask     = MAX_LEN'(len_mask(int'(r_len)));
  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);
  // Including the bit arriving now, enough fresh bits must exist to cover the pattern.
  assign w_fill_ok  = ({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, r_len};
  // A config load swallows any bit presented on the same cycle.
  assign w_advance  = x_valid & ~cfg_load;
  assign w_match    = w_advance & w_fill_ok & (((w_window ^ r_pattern) & w_mask) == '0);

  // Latch a new configuration; reset reproduces the legacy 10010 detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN;
      r_overlap <= 1'b1;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_cfg_len;
      r_overlap <= cfg_overlap;
    end
  end

  // Shift history and track fill; a load or a non-overlapping match restarts the fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (x_valid) begin
      r_hist <= w_window[MAX_LEN-2:0];
      r_fill <= (w_match && !r_overlap) ? '0 : w_fill_inc;
    end
  end

  // Match pulse, stream position counter and position of the latest match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z        <= 1'b0;
      r_bit_idx  <= '0;
      r_last_pos <= '0;
    end else begin
      r_z <= w_match;
      if (w_advance)
        r_bit_idx <= r_bit_idx + CNT_W'(1);
      if (w_match)
        r_last_pos <= r_bit_idx;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr_cnt),
    .i_inc (w_match),
    .o_cnt (match_cnt),
    .o_sat (cnt_sat)
  );

  assign z        = r_z;
  assign last_pos = r_last_pos;

endmodule
